// File: rtl/id_ex_forward_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_forward_pkg
// Shared definitions for the ID/EX forwarding register: opcode constants,
// instruction field positions, decode helpers and the stage state enum.
// ---------------------------------------------------------------------------
package id_ex_forward_pkg;

    localparam logic [3:0] OP_LW0  = 4'b0100;
    localparam logic [3:0] OP_LW1  = 4'b0110;
    localparam logic [3:0] OP_SW0  = 4'b0101;
    localparam logic [3:0] OP_SW1  = 4'b0111;
    localparam logic [3:0] OP_NONE = 4'b0000;

    // Field positions inside a 16-bit instruction word (each field is 4 bits)
    localparam int OPC_LSB = 12;
    localparam int DST_LSB = 8;
    localparam int RS_LSB  = 4;
    localparam int RT_LSB  = 0;

    typedef enum logic {
        RUN    = 1'b0,
        BUBBLE = 1'b1
    } state_t;

    function automatic logic [3:0] opcode(input logic [15:0] instr);
        return instr[OPC_LSB +: 4];
    endfunction

    function automatic logic [3:0] dest(input logic [15:0] instr);
        return instr[DST_LSB +: 4];
    endfunction

    function automatic logic [3:0] rs(input logic [15:0] instr);
        return instr[RS_LSB +: 4];
    endfunction

    function automatic logic [3:0] rt(input logic [15:0] instr);
        return instr[RT_LSB +: 4];
    endfunction

    function automatic logic is_load(input logic [15:0] instr);
        return (opcode(instr) == OP_LW0) || (opcode(instr) == OP_LW1);
    endfunction

    function automatic logic is_store(input logic [15:0] instr);
        return (opcode(instr) == OP_SW0) || (opcode(instr) == OP_SW1);
    endfunction

    // Opcode 0000 is the NOP/bubble encoding and never writes a register
    function automatic logic is_writer(input logic [15:0] instr);
        return !is_store(instr) && (opcode(instr) != OP_NONE);
    endfunction

endpackage

// File: rtl/id_ex_forward_if.sv
// ---------------------------------------------------------------------------
// id_ex_forward_if
// Bundles the IF/ID-side inputs, forwarding inputs and EX-side outputs of the
// ID/EX register.
//   slave  : the ID/EX register itself (consumes instruction/operands/forwards,
//            produces latched instruction/operands, Stall, BubbleCount)
//   master : the surrounding pipeline / testbench
// ---------------------------------------------------------------------------
interface id_ex_forward_if #(
    parameter int CNT_W = 16
);
    logic [15:0]      InstructionIn;
    logic [15:0]      OP1In;
    logic [15:0]      OP2In;
    logic [15:0]      OneAwayInstruction;
    logic [31:0]      OneAwayForward;
    logic [15:0]      TwoAwayInstruction;
    logic [31:0]      TwoAwayForward;
    logic             Hold;
    logic [15:0]      InstructionOut;
    logic [15:0]      OP1Out;
    logic [15:0]      OP2Out;
    logic             Stall;
    logic [CNT_W-1:0] BubbleCount;

    modport master (
        output InstructionIn, OP1In, OP2In,
        output OneAwayInstruction, OneAwayForward,
        output TwoAwayInstruction, TwoAwayForward,
        output Hold,
        input  InstructionOut, OP1Out, OP2Out, Stall, BubbleCount
    );

    modport slave (
        input  InstructionIn, OP1In, OP2In,
        input  OneAwayInstruction, OneAwayForward,
        input  TwoAwayInstruction, TwoAwayForward,
        input  Hold,
        output InstructionOut, OP1Out, OP2Out, Stall, BubbleCount
    );
endinterface

// File: rtl/id_ex_forward_fwd_select.sv
// ---------------------------------------------------------------------------
// fwd_select
// Per-operand forwarding priority mux.
//   src_i        : source register number being read
//   op_i         : register-file value for that source
//   one_instr_i  : instruction in MEM,  one_fwd_i : its forward value
//   two_instr_i  : instruction in WB,   two_fwd_i : its write-back value
//   op_o         : resolved operand (one-away > two-away > register file)
// ---------------------------------------------------------------------------
module fwd_select
    import id_ex_forward_pkg::*;
(
    input  logic [3:0]  src_i,
    input  logic [15:0] op_i,
    input  logic [15:0] one_instr_i,
    input  logic [31:0] one_fwd_i,
    input  logic [15:0] two_instr_i,
    input  logic [31:0] two_fwd_i,
    output logic [15:0] op_o
);

    // Only the low half of the forward buses carries register data
    logic unused_fwd_hi;
    assign unused_fwd_hi = ^{one_fwd_i[31:16], two_fwd_i[31:16]};

    always_comb begin
        op_o = op_i;
        // r0 is hard-wired and never forwarded
        if (src_i != 4'd0) begin
            if (is_writer(one_instr_i) && (dest(one_instr_i) == src_i)) begin
                op_o = one_fwd_i[15:0];
            end else if (is_writer(two_instr_i) && (dest(two_instr_i) == src_i)) begin
                op_o = two_fwd_i[15:0];
            end
        end
    end

endmodule

// File: rtl/id_ex_forward.sv
// ---------------------------------------------------------------------------
// id_ex_forward
// ID/EX pipeline register with operand forwarding and load-use interlock.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : id_ex_forward_if.slave
//          in : InstructionIn, OP1In, OP2In, One/TwoAwayInstruction,
//               One/TwoAwayForward, Hold
//          out: InstructionOut, OP1Out, OP2Out (registered),
//               Stall (combinational), BubbleCount (registered, saturating)
// ---------------------------------------------------------------------------
module id_ex_forward
    import id_ex_forward_pkg::*;
#(
    parameter logic [15:0] NOP   = 16'h0000,
    parameter int          CNT_W = 16
) (
    input logic               clk,
    input logic               rst,
    id_ex_forward_if.slave    bus
);

    state_t           state_q, state_d;
    logic [15:0]      instr_q, instr_d;
    logic [15:0]      op1_q, op1_d;
    logic [15:0]      op2_q, op2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [15:0] op1_fwd;
    logic [15:0] op2_fwd;
    logic        hazard;

    fwd_select u_fwd_op1 (
        .src_i       (rs(bus.InstructionIn)),
        .op_i        (bus.OP1In),
        .one_instr_i (bus.OneAwayInstruction),
        .one_fwd_i   (bus.OneAwayForward),
        .two_instr_i (bus.TwoAwayInstruction),
        .two_fwd_i   (bus.TwoAwayForward),
        .op_o        (op1_fwd)
    );

    fwd_select u_fwd_op2 (
        .src_i       (rt(bus.InstructionIn)),
        .op_i        (bus.OP2In),
        .one_instr_i (bus.OneAwayInstruction),
        .one_fwd_i   (bus.OneAwayForward),
        .two_instr_i (bus.TwoAwayInstruction),
        .two_fwd_i   (bus.TwoAwayForward),
        .op_o        (op2_fwd)
    );

    // A load sitting in EX cannot forward its data yet; any reader of its
    // destination must wait one cycle. Gated by rst so Stall is low in reset.
    always_comb begin
        hazard = rst && (state_q == RUN) && is_load(instr_q)
                 && (dest(instr_q) != 4'd0)
                 && ((dest(instr_q) == rs(bus.InstructionIn)) ||
                     (dest(instr_q) == rt(bus.InstructionIn)));
    end

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        cnt_d   = cnt_q;
        if (!bus.Hold) begin
            if ((state_q == RUN) && hazard) begin
                instr_d = NOP;
                op1_d   = 16'h0000;
                op2_d   = 16'h0000;
                cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q
                          : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                state_d = BUBBLE;
            end else begin
                // RUN without hazard, or BUBBLE (load data now comes one-away)
                instr_d = bus.InstructionIn;
                op1_d   = op1_fwd;
                op2_d   = op2_fwd;
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            instr_q <= NOP;
            op1_q   <= 16'h0000;
            op2_q   <= 16'h0000;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.InstructionOut = instr_q;
    assign bus.OP1Out         = op1_q;
    assign bus.OP2Out         = op2_q;
    assign bus.BubbleCount    = cnt_q;
    assign bus.Stall          = hazard;

endmodule

// File: tb/tb_id_ex_forward.sv
module tb_id_ex_forward;

    localparam int CNT_W = 4;

    typedef struct {
        int          id;
        logic        stall;
        logic [15:0] instr;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [3:0]  cnt;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   vid   = 0;
    int   ec;

    id_ex_forward_if #(.CNT_W(CNT_W)) bus_if ();

    id_ex_forward #(.NOP(16'h0000), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL v%0d %s: got %h expected %h", id, nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue what must appear after the next edge
    task automatic step(input logic es, input logic [15:0] ei, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [3:0] ecnt,
                        input logic [15:0] ii, input logic [15:0] o1, input logic [15:0] o2,
                        input logic [15:0] oi = 16'h0000, input logic [31:0] of = 32'h0,
                        input logic [15:0] ti = 16'h0000, input logic [31:0] tf = 32'h0,
                        input logic h = 1'b0);
        exp_t e;
        @(negedge clk);
        bus_if.InstructionIn      = ii;
        bus_if.OP1In              = o1;
        bus_if.OP2In              = o2;
        bus_if.OneAwayInstruction = oi;
        bus_if.OneAwayForward     = of;
        bus_if.TwoAwayInstruction = ti;
        bus_if.TwoAwayForward     = tf;
        bus_if.Hold               = h;
        vid++;
        e.id = vid; e.stall = es; e.instr = ei; e.op1 = e1; e.op2 = e2; e.cnt = ecnt;
        sb.push_back(e);
    endtask

    // Monitor: Stall is checked mid-cycle, registered outputs just after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.id, "Stall", {31'b0, bus_if.Stall}, {31'b0, e.stall});
                @(posedge clk);
                #1;
                chk(e.id, "InstructionOut", {16'b0, bus_if.InstructionOut}, {16'b0, e.instr});
                chk(e.id, "OP1Out", {16'b0, bus_if.OP1Out}, {16'b0, e.op1});
                chk(e.id, "OP2Out", {16'b0, bus_if.OP2Out}, {16'b0, e.op2});
                chk(e.id, "BubbleCount", {28'b0, bus_if.BubbleCount}, {28'b0, e.cnt});
            end
        end
    end

    initial begin
        rst = 1'b0;
        bus_if.InstructionIn      = 16'h0000;
        bus_if.OP1In              = 16'h0000;
        bus_if.OP2In              = 16'h0000;
        bus_if.OneAwayInstruction = 16'h0000;
        bus_if.OneAwayForward     = 32'h0;
        bus_if.TwoAwayInstruction = 16'h0000;
        bus_if.TwoAwayForward     = 32'h0;
        bus_if.Hold               = 1'b0;
        #1;
        chk(0, "rst InstructionOut", {16'b0, bus_if.InstructionOut}, 32'h0);
        chk(0, "rst OP1Out", {16'b0, bus_if.OP1Out}, 32'h0);
        chk(0, "rst OP2Out", {16'b0, bus_if.OP2Out}, 32'h0);
        chk(0, "rst BubbleCount", {28'b0, bus_if.BubbleCount}, 32'h0);
        chk(0, "rst Stall", {31'b0, bus_if.Stall}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // One-away forward of r3
        step(0, 16'h2534, 16'hBEEF, 16'h2222, 4'd0, 16'h2534, 16'h1111, 16'h2222,
             16'h1312, 32'h0000_BEEF);
        // Both write r4: one-away wins; rs=r0 passes OP1In
        step(0, 16'h2304, 16'h0A0A, 16'hAAAA, 4'd0, 16'h2304, 16'h0A0A, 16'h0B0B,
             16'h1400, 32'hFFFF_AAAA, 16'h3400, 32'h0000_5555);
        // Store in MEM is not a writer; two-away load writes r6
        step(0, 16'h2056, 16'h1234, 16'h7777, 4'd0, 16'h2056, 16'h1234, 16'h5678,
             16'h5500, 32'h0000_9999, 16'h6600, 32'h0000_7777);
        // Writer to r0 never forwards
        step(0, 16'h2100, 16'h0101, 16'h0202, 4'd0, 16'h2100, 16'h0101, 16'h0202,
             16'h1000, 32'h0000_DEAD);
        // Load-use on r7
        step(0, 16'h4700, 16'h0000, 16'h0000, 4'd0, 16'h4700, 16'h0000, 16'h0000);
        step(1, 16'h0000, 16'h0000, 16'h0000, 4'd1, 16'h2871, 16'h3333, 16'h4444);
        step(0, 16'h2871, 16'h00C3, 16'h4444, 4'd1, 16'h2871, 16'h3333, 16'h4444,
             16'h4700, 32'h0000_00C3);
        // Hazard under Hold for three cycles, then bubble
        step(0, 16'h6900, 16'h0000, 16'h0000, 4'd1, 16'h6900, 16'h0000, 16'h0000);
        for (int i = 0; i < 3; i++)
            step(1, 16'h6900, 16'h0000, 16'h0000, 4'd1, 16'h2090, 16'h1010, 16'h2020,
                 16'h0000, 32'h0, 16'h0000, 32'h0, 1'b1);
        step(1, 16'h0000, 16'h0000, 16'h0000, 4'd2, 16'h2090, 16'h1010, 16'h2020);
        step(0, 16'h2090, 16'hABCD, 16'h2020, 4'd2, 16'h2090, 16'h1010, 16'h2020,
             16'h6900, 32'h0000_ABCD);
        // Back-to-back load-use chains
        step(0, 16'h4A00, 16'h0000, 16'h0000, 4'd2, 16'h4A00, 16'h0000, 16'h0000);
        step(1, 16'h0000, 16'h0000, 16'h0000, 4'd3, 16'h4BA0, 16'h0077, 16'h0088);
        step(0, 16'h4BA0, 16'h1111, 16'h0088, 4'd3, 16'h4BA0, 16'h0077, 16'h0088,
             16'h4A00, 32'h0000_1111);
        step(1, 16'h0000, 16'h0000, 16'h0000, 4'd4, 16'h20B0, 16'h0005, 16'h0006);
        step(0, 16'h20B0, 16'h2222, 16'h0006, 4'd4, 16'h20B0, 16'h0005, 16'h0006,
             16'h4BA0, 32'h0000_2222);
        // Store in EX and load to r0 cause no interlock
        step(0, 16'h5300, 16'h0000, 16'h0000, 4'd4, 16'h5300, 16'h0000, 16'h0000);
        step(0, 16'h2030, 16'h0303, 16'h0404, 4'd4, 16'h2030, 16'h0303, 16'h0404);
        step(0, 16'h4000, 16'h0000, 16'h0000, 4'd4, 16'h4000, 16'h0000, 16'h0000);
        step(0, 16'h2000, 16'h0001, 16'h0002, 4'd4, 16'h2000, 16'h0001, 16'h0002);
        // Saturation of the 4-bit counter
        ec = 4;
        for (int i = 0; i < 14; i++) begin
            step(0, 16'h4700, 16'h0000, 16'h0000, 4'(ec), 16'h4700, 16'h0000, 16'h0000);
            ec = (ec == 15) ? 15 : ec + 1;
            step(1, 16'h0000, 16'h0000, 16'h0000, 4'(ec), 16'h2070, 16'h0009, 16'h000A);
            step(0, 16'h2070, 16'h0C0C, 16'h000A, 4'(ec), 16'h2070, 16'h0009, 16'h000A,
                 16'h4700, 32'h0000_0C0C);
        end
        // Reset while in BUBBLE
        step(0, 16'h4700, 16'h0000, 16'h0000, 4'd15, 16'h4700, 16'h0000, 16'h0000);
        step(1, 16'h0000, 16'h0000, 16'h0000, 4'd15, 16'h2070, 16'h0009, 16'h000A);
        @(posedge clk);
        #3;
        bus_if.InstructionIn = 16'h2070;
        rst = 1'b0;
        #1;
        chk(99, "midrst InstructionOut", {16'b0, bus_if.InstructionOut}, 32'h0);
        chk(99, "midrst OP1Out", {16'b0, bus_if.OP1Out}, 32'h0);
        chk(99, "midrst OP2Out", {16'b0, bus_if.OP2Out}, 32'h0);
        chk(99, "midrst BubbleCount", {28'b0, bus_if.BubbleCount}, 32'h0);
        chk(99, "midrst Stall", {31'b0, bus_if.Stall}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step(0, 16'h2070, 16'h0009, 16'h000A, 4'd0, 16'h2070, 16'h0009, 16'h000A);
        @(posedge clk);
        #3;
        chk(100, "scoreboard drained", sb.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
